gem_cluster_tx: RTL

//  GEM trigger-link frame transmitter: far end of the OTMB GEM optical receiver path.
//  A cluster buffer is loaded one 14-bit cluster per clock. On tx_start the block replays the buffer as 56-bit link frames, 4 clusters per bx.

---
 rtl/gem_cluster_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gem_cluster_tx.sv
// gem_cluster_tx: GEM trigger-link frame transmitter.
// Clusters are loaded one per clock into a buffer, then replayed as 56-bit
// link frames (4 clusters per bx), unused slots padded with the idle cluster.
// Optional build macro GEM_TX_PRBS_EN adds a prbs_sel input and a 56-bit
// PRBS source that replaces idle frames while selected.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | buffer writable, output idle frames (or PRBS when selected)
// SEND  | replay buffer, one frame per clock, 4 clusters per frame
module gem_cluster_tx #(
  parameter int          BUF_DEPTH = 64,
  parameter int          BUF_ADRB  = 6,
  parameter logic [13:0] IDLE_CLST = 14'h07FF
) (
  input  logic                clock,
  input  logic                global_reset_n,
  input  logic                ttc_resync,
  input  logic                wr_en,
  input  logic [13:0]         wr_data,
  input  logic                wr_clear,
  input  logic                tx_start,
  input  logic                tx_loop,
`ifdef GEM_TX_PRBS_EN
  input  logic                prbs_sel,
`endif
  output logic [55:0]         gtx_tx_data,
  output logic                gtx_tx_valid,
  output logic                tx_busy,
  output logic [BUF_ADRB:0]   clst_count,
  output logic                wr_overflow,
  output logic [15:0]         frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [BUF_ADRB:0]   DEPTH_C = (BUF_ADRB+1)'(BUF_DEPTH);
  localparam logic [BUF_ADRB:0]   STEP_C  = (BUF_ADRB+1)'(4);
  localparam logic [BUF_ADRB+1:0] STEP_W  = (BUF_ADRB+2)'(4);

  state_t              state, state_nxt;
  logic [BUF_ADRB:0]   rd_ptr;
  logic [13:0]         clst_buf [BUF_DEPTH];
  logic                last_frame;
  logic                go;
  logic                wr_ok;
  logic                prbs_hold;
  logic [55:0]         frame_nxt;
  logic                valid_nxt;
  logic [BUF_ADRB+1:0] idx;
  logic [13:0]         slot;

`ifdef GEM_TX_PRBS_EN
  logic [55:0] lfsr;
  assign prbs_hold = prbs_sel;
`else
  assign prbs_hold = 1'b0;
`endif

  assign tx_busy = (state == SEND);
  // Writes only land while idle; a clear in the same cycle wins.
  assign wr_ok   = (state == IDLE) && wr_en && !wr_clear && (clst_count < DEPTH_C);

  // State register
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) state <= IDLE;
    else                 state <= state_nxt;
  end

  // Next state, last-frame detect and frame assembly from the buffer
  always_comb begin
    state_nxt  = state;
    go         = 1'b0;
    last_frame = (({1'b0, rd_ptr} + STEP_W) >= {1'b0, clst_count});
    frame_nxt  = '0;
    valid_nxt  = 1'b0;
    idx        = '0;
    slot       = IDLE_CLST;
    case (state)
      IDLE: begin
        go = tx_start && !ttc_resync && (clst_count != '0) && !prbs_hold;
        if (go) state_nxt = SEND;
      end
      SEND: begin
        if (ttc_resync)                   state_nxt = IDLE;
        else if (last_frame && !tx_loop)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    for (int k = 0; k < 4; k++) begin
      idx = {1'b0, rd_ptr} + (BUF_ADRB+2)'(k);
      if (idx < {1'b0, clst_count}) slot = clst_buf[idx[BUF_ADRB-1:0]];
      else                          slot = IDLE_CLST;
      frame_nxt[14*k +: 14] = slot;
      valid_nxt = valid_nxt | (slot[10:9] != 2'b11);
    end
  end

  // Read pointer, fill count, overflow flag and sent-frame counter
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      rd_ptr      <= '0;
      clst_count  <= '0;
      wr_overflow <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (state == SEND && !ttc_resync && !last_frame) rd_ptr <= rd_ptr + STEP_C;
      else                                             rd_ptr <= '0;

      if (wr_clear) begin
        clst_count  <= '0;
        wr_overflow <= 1'b0;
      end else if (wr_ok) begin
        clst_count <= clst_count + 1'b1;
      end else if (state == IDLE && wr_en && clst_count == DEPTH_C) begin
        wr_overflow <= 1'b1;
      end

      if (ttc_resync)                       frame_cnt <= '0;
      else if (state == SEND && !(&frame_cnt)) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Cluster storage; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (wr_ok) clst_buf[clst_count[BUF_ADRB-1:0]] <= wr_data;
  end

  // Registered link frame and its valid flag
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      gtx_tx_data  <= {4{IDLE_CLST}};
      gtx_tx_valid <= 1'b0;
    end else if (state == SEND && !ttc_resync) begin
      gtx_tx_data  <= frame_nxt;
      gtx_tx_valid <= valid_nxt;
    end else begin
`ifdef GEM_TX_PRBS_EN
      gtx_tx_data  <= (prbs_sel && state == IDLE) ? lfsr : {4{IDLE_CLST}};
`else
      gtx_tx_data  <= {4{IDLE_CLST}};
`endif
      gtx_tx_valid <= 1'b0;
    end
  end

`ifdef GEM_TX_PRBS_EN
  // Free-running Fibonacci LFSR, taps 56,55,35,34
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) lfsr <= 56'h1;
    else                 lfsr <= {lfsr[54:0], lfsr[55] ^ lfsr[54] ^ lfsr[34] ^ lfsr[33]};
  end
`endif

endmodule
